// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared Wishbone B3 cycle/burst type encodings and slave FSM states.
// Revision : 1.0  initial release
// ============================================================================
package wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CLASSIC = 2'd1,
      ST_BURST   = 2'd2
   } wb_slv_state_e;

   // Constant-address and the 011..110 reserved codes are rejected by slaves.
   function automatic logic cti_is_unsupported(input logic [2:0] cti);
      return (cti == CTI_CONST) || ((cti >= 3'b011) && (cti <= 3'b110));
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_sp_ram.sv
`default_nettype none
// ============================================================================
// Module   : wb_sp_ram
// Brief    : Single-port synchronous RAM, 2^AW x 32, four byte-write enables,
//            read-first, output register cleared by asynchronous reset.
// Revision : 1.0  initial release
// ============================================================================
module wb_sp_ram #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] i_addr,
   input  logic [3:0]    i_be,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [2**AW];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (i_be[b]) begin
            r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= 32'h0;
      end else begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/wb_burst_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : wb_burst_ram_slave
// Brief    : Wishbone B3 RAM slave, classic and incrementing-burst cycles.
//            Burst support is compiled in only when WB_RAM_BURST_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module wb_burst_ram_slave
   import wb_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic        wb_clk,
   input  logic        wb_rst_n,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic [31:2] addr_i,
   input  logic [2:0]  cti_i,
   input  logic [1:0]  bte_i,
   input  logic [3:0]  sel_i,
   input  logic        we_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        ack_o,
   output logic        err_o
);

   wb_slv_state_e r_state;
   wb_slv_state_e w_state_nxt;
   logic          r_ack;
   logic          w_ack_nxt;
   logic          r_err;
   logic          w_err_nxt;
   logic [AW-1:0] w_offset;
   logic          w_req;
   logic          w_addr_bad;
   logic          w_cti_bad;
   logic          w_is_burst;
   logic [AW-1:0] w_ram_addr;
   logic          w_ram_we;
   logic [3:0]    w_ram_be;

   assign w_offset   = addr_i[AW+1:2];
   assign w_req      = cyc_i & stb_i & ~r_ack & ~r_err;
   assign w_addr_bad = |addr_i[31:AW+2];

`ifdef WB_RAM_BURST_EN
   logic [AW-1:0] r_ptr;
   logic [AW-1:0] w_ptr_nxt;
   logic [AW-1:0] w_ptr_adv;
   logic [AW-1:0] w_wrap_mask;
   logic          w_beat;

   assign w_cti_bad  = cti_is_unsupported(cti_i);
   assign w_is_burst = (cti_i == CTI_INCR);
   assign w_beat     = cyc_i & stb_i & r_ack;

   // Bits under the mask count, bits above it stay fixed.
   always_comb begin
      w_wrap_mask = '1;
      case (bte_i)
         BTE_WRAP4:  w_wrap_mask = AW'(3);
         BTE_WRAP8:  w_wrap_mask = AW'(7);
         BTE_WRAP16: w_wrap_mask = AW'(15);
         default:    w_wrap_mask = '1;
      endcase
   end

   assign w_ptr_adv = (r_ptr & ~w_wrap_mask) | ((r_ptr + AW'(1)) & w_wrap_mask);

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_ptr <= '0;
      end else begin
         r_ptr <= w_ptr_nxt;
      end
   end
`else
   logic w_unused_burst;

   assign w_cti_bad      = 1'b0;
   assign w_is_burst     = 1'b0;
   assign w_unused_burst = ^{cti_i, bte_i};
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      w_ram_addr  = w_offset;
      w_ram_we    = 1'b0;
`ifdef WB_RAM_BURST_EN
      w_ptr_nxt   = r_ptr;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               if (w_addr_bad || w_cti_bad) begin
                  w_err_nxt = 1'b1;
               end else if (w_is_burst) begin
                  w_state_nxt = ST_BURST;
                  w_ack_nxt   = 1'b1;
`ifdef WB_RAM_BURST_EN
                  w_ptr_nxt   = w_offset;
`endif
               end else begin
                  w_state_nxt = ST_CLASSIC;
                  w_ack_nxt   = 1'b1;
                  w_ram_we    = we_i;
               end
            end
         end
         ST_CLASSIC: begin
            w_state_nxt = ST_IDLE;
         end
`ifdef WB_RAM_BURST_EN
         ST_BURST: begin
            w_ram_addr = r_ptr;
            if (!cyc_i) begin
               w_state_nxt = ST_IDLE;
            end else begin
               // One RAM port: a write beat needs ptr, a read beat prefetches the successor.
               if (w_beat) begin
                  w_ram_we  = we_i;
                  w_ptr_nxt = w_ptr_adv;
                  if (!we_i) begin
                     w_ram_addr = w_ptr_adv;
                  end
               end
               if (w_beat && (cti_i == CTI_EOB)) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_ack_nxt = stb_i;
               end
            end
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_ram_be = w_ram_we ? sel_i : 4'b0000;

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_state <= ST_IDLE;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign ack_o = r_ack;
   assign err_o = r_err;

   wb_sp_ram #(
      .AW (AW)
   ) u_ram (
      .clk     (wb_clk),
      .rst_n   (wb_rst_n),
      .i_addr  (w_ram_addr),
      .i_be    (w_ram_be),
      .i_wdata (data_i),
      .o_rdata (data_o)
   );

endmodule
`default_nettype wire

// File: doc/wb_burst_ram_slave.md
# wb_burst_ram_slave

Wishbone B3 slave responder for the arbiter's slave ports: a single-port, byte-writable on-chip RAM that answers classic and registered-feedback incrementing-burst cycles. It sits behind a slave port of the bus arbiter, for example the RAM slot, and responds to whichever master the arbiter has granted. The arbiter has already decoded the region, so this block decodes only the word offset. It flags out-of-range or unsupported cycles with `err_o`.

## Interface
- `AW`, default 10: word-address width; memory depth is 2^AW 32-bit words.
- `wb_clk`  in  1  Wishbone clock; all logic on rising edge.
- `wb_rst_n`  in  1  asynchronous, active-low reset.
- `cyc_i`, `stb_i`  in  1 each  bus-cycle and strobe.
- `addr_i`  in  [31:2]  word address.
- `cti_i`  in  3  cycle type.
- `bte_i`  in  2  burst type.
- `sel_i`  in  4  byte selects.
- `we_i`  in  1  write enable.
- `data_i`  in  32  write data.
- `data_o`  out  32  read data, valid while `ack_o` is high.
- `ack_o`  out  1  beat acknowledge.
- `err_o`  out  1  error termination.

## Operation
- **Request**: `cyc_i & stb_i` while neither `ack_o` nor `err_o` is high. The word offset is `addr_i[AW+1:2]`.
- **Error check** at the request cycle. `err_o` pulses for 1 cycle, with no write and no ack, if either:
  - `addr_i[31:AW+2] != 0`, or
  - `cti_i` is one of 001 or 011–110.
- **FSM states**: IDLE, CLASSIC, BURST.
- **IDLE to CLASSIC**: valid request with `cti_i` equal to 000 or 111.
  - The write (if `we_i`) occurs on that edge.
  - `ack_o` is 1 for exactly one cycle, then the FSM returns to IDLE.
- **IDLE to BURST**: valid request with `cti_i=010`.
  - Burst pointer `ptr` is loaded from `addr_i`.
  - `ack_o` rises next cycle.
- **BURST**:
  - A beat completes on a cycle where `ack_o & stb_i`.
  - On each beat, a write stores `data_i` at `ptr` using `sel_i`, then `ptr` advances.
  - After the first beat, the slave ignores `addr_i` and uses `ptr` only.
  - **Advance per bte**:
    - 00 linear: `ptr+1`, wrapping modulo 2^AW.
    - 01 wrap4: `ptr[1:0]+1`.
    - 10 wrap8: `ptr[2:0]+1`.
    - 11 wrap16: `ptr[3:0]+1`.
    - Upper bits are held in all wrap modes.
  - **Master wait state** (`stb_i=0`, `cyc_i=1`): `ack_o` drops next cycle, `ptr` and read data are held, and `ack_o` resumes the cycle after `stb_i` returns.
  - A beat with `cti_i=111` is the last beat. `ack_o` drops next cycle and the FSM goes to IDLE.
- **Abort**: `cyc_i=0` in any state sends the FSM to IDLE and zeroes `ack_o` next cycle. A write is not performed unless that cycle's beat had already completed.
- **Reads**: the synchronous RAM read address is:
  - `addr_i` offset in IDLE;
  - `ptr`'s successor on a completing burst beat;
  - `ptr` otherwise.
- `we_i` is held constant by the master for a whole burst.

## Timing
- **Reset values**: `ack_o=0`, `err_o=0`, `data_o=0`, state IDLE, `ptr=0`. RAM contents are not cleared.
- Reset asserted mid-burst forces the outputs above immediately (asynchronously).
- **Classic access**: `ack_o` or `err_o` appears 1 cycle after the request and is never asserted 2 cycles in a row. Throughput is 1 access per 2 cycles.
- **Burst**: first ack 1 cycle after the request, then 1 beat per cycle. An N-beat burst takes N+1 cycles.
- **Read latency**: `data_o` is valid in the same cycle as `ack_o`.
- `ack_o` and `err_o` are never high together.

## Configuration
- `WB_RAM_BURST_EN` defined: full behaviour as specified above.
- Not defined:
  - BURST state, `ptr` and wrap logic are removed.
  - `cti_i` and `bte_i` are ignored and every request is handled as CLASSIC.
  - Only the address-range error remains.

## Structure
- **Shared package `wb_pkg`**:
  - CTI constants: CLASSIC=000, CONST=001, INCR=010, EOB=111.
  - BTE constants: LINEAR, WRAP4, WRAP8, WRAP16.
  - The slave FSM state enum.
  - The `wb_pkg` constants are reused by the arbiter and the other slaves.
- **Sub-module `wb_sp_ram`**: single-port synchronous RAM, depth 2^AW × 32, with 4 byte-write enables. The FSM and address logic stay in the top-level module.

## Test plan
- **Classic write then read**: write 0xDEADBEEF to addr 0x5, `sel=1111`; read addr 0x5 → `ack_o` 1 cycle after stb, `data_o=0xDEADBEEF`, then `ack_o=0`.
- **Byte select**: write 0x11223344 to addr 0x5 with `sel=0010`, then read → 0xDEAD33EF.
- **Wrap4 read burst**: preload words 0–7 with their index; burst from addr 6, `bte=01`, 4 beats with the last at `cti=111` → data 6, 7, 4, 5 on consecutive acks, then `ack_o=0` and FSM in IDLE.
- **Linear wrap-around**: burst write with `bte=00` starting at address 2^AW−1 for 2 beats → second word lands at address 0.
- **Wait state and abort**: drop `stb_i` for 2 cycles mid-burst → ack gap, no pointer skip. `cyc_i=0` mid-burst → IDLE with no extra write.
- **Errors and reset**:
  - `addr_i = 1<<(AW+2)` → single `err_o`, memory unchanged.
  - `cti=001` with `WB_RAM_BURST_EN` defined → `err_o`.
  - `wb_rst_n` low mid-burst → `ack_o=0` immediately.
